// File: rtl/apb_master.sv
// Single-channel APB master: one request at a time -> SETUP/ACCESS on an 8-slave bus.
// Optional ACCESS-phase timeout is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
   parameter int SEL_LSB        = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        PCLK,
   input  logic        PRST_N,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_strb,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [7:0]  PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   output logic [3:0]  PSTRB,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        PSLVERR
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

   state_t      r_state;
   logic [7:0]  r_psel;
   logic        r_penable;
   logic        r_pwrite;
   logic [31:0] r_paddr;
   logic [31:0] r_pwdata;
   logic [3:0]  r_pstrb;
   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;

   logic [31:0] w_hi_bits;
   logic        w_illegal;
   logic [2:0]  w_idx;

   // Address bits above the slave index must be zero, otherwise it is a decode error.
   assign w_hi_bits = req_addr >> (SEL_LSB + 3);
   assign w_illegal = |w_hi_bits;
   assign w_idx     = req_addr[SEL_LSB +: 3];

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] r_to_cnt;
`endif

   always_ff @(posedge PCLK) begin
      if (!PRST_N) begin
         r_state     <= ST_IDLE;
         r_psel      <= '0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_pstrb     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         r_to_cnt    <= '0;
`endif
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  if (w_illegal) begin
                     // Decode error answers immediately and never touches the bus.
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                  end else begin
                     r_paddr  <= req_addr;
                     r_pwrite <= req_write;
                     r_pwdata <= req_wdata;
                     r_pstrb  <= req_write ? req_strb : 4'b0000;
                     r_psel   <= 8'(1) << w_idx;
                     r_state  <= ST_SETUP;
                  end
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
               r_to_cnt  <= '0;
`endif
            end
            ST_ACCESS: begin
               if (PREADY) begin
                  r_psel      <= '0;
                  r_penable   <= 1'b0;
                  r_state     <= ST_IDLE;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= PSLVERR;
                  r_rsp_rdata <= r_pwrite ? 32'h0 : PRDATA;
               end
`ifdef APB_MASTER_TIMEOUT_EN
               else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  r_psel      <= '0;
                  r_penable   <= 1'b0;
                  r_state     <= ST_IDLE;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
`endif
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = (r_state == ST_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;
   assign PWRITE    = r_pwrite;
   assign PADDR     = r_paddr;
   assign PWDATA    = r_pwdata;
   assign PSTRB     = r_pstrb;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: stimulus pushes expected responses, a negedge monitor pops and checks them.
module tb_apb_master;

   logic        PCLK = 1'b0;
   logic        PRST_N = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_strb = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [7:0]  PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [31:0] PRDATA = '0;
   logic        PREADY = 1'b0;
   logic        PSLVERR = 1'b0;

   apb_master #(.SEL_LSB(12), .TIMEOUT_CYCLES(16)) dut (
      .PCLK(PCLK), .PRST_N(PRST_N),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor: every rsp_valid must match the oldest expectation, including its cycle.
   always @(negedge PCLK) begin
      if (rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Full legal transfer, called at a negedge with the master idle.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int waits, input logic [31:0] rd,
                       input logic slverr, input logic [7:0] exp_psel,
                       input logic [31:0] exp_rdata, input string tag);
      exp_t e;
      int   c;
      logic [3:0] exp_strb;
      c = cyc;
      exp_strb = wr ? strb : 4'h0;
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_strb = strb;
      PRDATA = rd; PSLVERR = slverr; PREADY = 1'b0;
      e.rdata = exp_rdata; e.err = slverr; e.cyc = c + 3 + waits;
      exp_q.push_back(e);
      @(negedge PCLK);
      req_valid = 1'b0;
      chk({tag, "_setup_psel"}, 32'(PSEL), 32'(exp_psel));
      chk({tag, "_setup_penable"}, 32'(PENABLE), 32'h0);
      chk({tag, "_setup_ready"}, 32'(req_ready), 32'h0);
      chk({tag, "_paddr"}, PADDR, addr);
      chk({tag, "_pwrite"}, 32'(PWRITE), 32'(wr));
      chk({tag, "_pstrb"}, 32'(PSTRB), 32'(exp_strb));
      if (wr) chk({tag, "_pwdata"}, PWDATA, wdata);
      for (int k = 0; k <= waits; k++) begin
         @(negedge PCLK);
         PREADY = (k >= waits);
         chk({tag, "_acc_penable"}, 32'(PENABLE), 32'h1);
         chk({tag, "_acc_psel"}, 32'(PSEL), 32'(exp_psel));
         chk({tag, "_acc_paddr"}, PADDR, addr);
         chk({tag, "_acc_pstrb"}, 32'(PSTRB), 32'(exp_strb));
      end
      @(negedge PCLK);
      PREADY = 1'b0; PSLVERR = 1'b0;
      chk({tag, "_done_psel"}, 32'(PSEL), 32'h0);
      chk({tag, "_done_penable"}, 32'(PENABLE), 32'h0);
      chk({tag, "_done_ready"}, 32'(req_ready), 32'h1);
   endtask

   // Decode-error request: one cycle, no bus activity.
   task automatic bad_req(input logic [31:0] addr, input string tag);
      exp_t e;
      e.rdata = 32'h0; e.err = 1'b1; e.cyc = cyc + 1;
      exp_q.push_back(e);
      req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
      @(negedge PCLK);
      req_valid = 1'b0;
      chk({tag, "_psel"}, 32'(PSEL), 32'h0);
      chk({tag, "_penable"}, 32'(PENABLE), 32'h0);
      chk({tag, "_ready"}, 32'(req_ready), 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge PCLK);
      chk("rst_psel", 32'(PSEL), 32'h0);
      chk("rst_penable", 32'(PENABLE), 32'h0);
      chk("rst_paddr", PADDR, 32'h0);
      chk("rst_pwdata", PWDATA, 32'h0);
      chk("rst_pstrb", 32'(PSTRB), 32'h0);
      chk("rst_ready", 32'(req_ready), 32'h1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      PRST_N = 1'b1;
      @(negedge PCLK);

      xfer(1'b1, 32'h0000_1004, 32'h9, 4'hF, 0, 32'hAAAA_5555, 1'b0, 8'h02, 32'h0, "gpio_wr");
      xfer(1'b0, 32'h0000_0000, 32'h0, 4'hF, 2, 32'h0000_0007, 1'b0, 8'h01, 32'h7, "uart_rd");
      xfer(1'b0, 32'h0000_1008, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b1, 8'h02, 32'hDEAD_BEEF, "slverr_rd");
      xfer(1'b1, 32'h0000_7FFC, 32'h1234_ABCD, 4'h3, 0, 32'h0, 1'b0, 8'h80, 32'h0, "b2b_wr7");
      xfer(1'b0, 32'h0000_5010, 32'h0, 4'h0, 1, 32'h1234_5678, 1'b0, 8'h20, 32'h1234_5678, "b2b_rd5");
      xfer(1'b1, 32'h0000_3000, 32'h55, 4'h1, 0, 32'hFFFF_FFFF, 1'b1, 8'h08, 32'h0, "slverr_wr");

      bad_req(32'h0001_0000, "dec1");
      xfer(1'b1, 32'h0000_1000, 32'hC3, 4'hC, 0, 32'h0, 1'b0, 8'h02, 32'h0, "after_dec");
      bad_req(32'h8000_6000, "dec2");
      @(negedge PCLK);

      // Reset during the second ACCESS cycle drops the transfer silently.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_4020;
      req_wdata = 32'hFACE_0001; req_strb = 4'hF; PREADY = 1'b0;
      @(negedge PCLK); req_valid = 1'b0;
      @(negedge PCLK);
      chk("rstx_acc1_penable", 32'(PENABLE), 32'h1);
      @(negedge PCLK);
      PRST_N = 1'b0;
      @(negedge PCLK);
      chk("rstx_psel", 32'(PSEL), 32'h0);
      chk("rstx_penable", 32'(PENABLE), 32'h0);
      chk("rstx_pwrite", 32'(PWRITE), 32'h0);
      chk("rstx_paddr", PADDR, 32'h0);
      chk("rstx_pwdata", PWDATA, 32'h0);
      chk("rstx_pstrb", 32'(PSTRB), 32'h0);
      chk("rstx_ready", 32'(req_ready), 32'h1);
      chk("rstx_rsp_valid", 32'(rsp_valid), 32'h0);
      PRST_N = 1'b1;
      @(negedge PCLK);
      chk("rstx_post_rsp_valid", 32'(rsp_valid), 32'h0);

`ifdef APB_MASTER_TIMEOUT_EN
      begin
         exp_t e;
         int   c;
         c = cyc;
         e.rdata = 32'h0; e.err = 1'b1; e.cyc = c + 2 + 16;
         exp_q.push_back(e);
         req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_6000;
         PRDATA = 32'h1111_2222; PREADY = 1'b0;
         @(negedge PCLK); req_valid = 1'b0;
         for (int k = 1; k <= 16; k++) begin
            @(negedge PCLK);
            chk("to_psel_held", 32'(PSEL), 32'h40);
         end
         @(negedge PCLK);
         chk("to_psel_drop", 32'(PSEL), 32'h0);
         chk("to_penable_drop", 32'(PENABLE), 32'h0);
         chk("to_ready", 32'(req_ready), 32'h1);
      end
`else
      xfer(1'b0, 32'h0000_6000, 32'h0, 4'h0, 20, 32'h1111_2222, 1'b0, 8'h40, 32'h1111_2222, "long_wait");
`endif

      repeat (3) @(negedge PCLK);
      chk("pending_rsp", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
